// File: rtl/result_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_rd_pkg
// Description : Shared widths and FSM state encoding for the result RAM reader.
// Revision    : 1.0 - initial release
// ============================================================================
package result_rd_pkg;

    localparam int c_ADDR_W = 3;
    localparam int c_DATA_W = 8;
    localparam int c_CNT_W  = c_ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/result_ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : result_ram_reader
// Description : Drains a wrapping range of the result RAM onto a valid/ready
//               stream, one beat per read, with last-beat flag and done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module result_ram_reader
    import result_rd_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int CNT_W  = c_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_rd_addr_hold;
    logic [CNT_W-1:0]    r_rem;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;
    logic                r_done;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start && (count != '0)) w_state_next = READ;
            READ:    w_state_next = CAPTURE;
            CAPTURE: w_state_next = PRESENT;
            PRESENT: begin
                if (out_ready) begin
                    w_state_next = (r_rem != '0) ? READ : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_rd_addr_hold <= '0;
            r_rem          <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_last     <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            r_addr <= base_addr;
                            r_rem  <= count;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    r_rd_addr_hold <= r_addr;
                end
                CAPTURE: begin
                    r_out_data  <= ram_rd_data;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_rem == CNT_W'(1));
                    r_addr      <= r_addr + ADDR_W'(1);
                    r_rem       <= r_rem - CNT_W'(1);
                end
                PRESENT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_rem == '0) r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address is driven live during READ and frozen afterwards so the RAM port sees a stable value.
    assign ram_rd_en   = (r_state == READ);
    assign ram_rd_addr = ram_rd_en ? r_addr : r_rd_addr_hold;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_result_ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_ram_reader
// Description : Scoreboard bench for result_ram_reader with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_ram_reader;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       first;
        int         acc;
    } beat_t;

    typedef struct {
        logic [2:0] addr;
        logic       first;
        int         acc;
    } raddr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] base_addr;
    logic [3:0] count;
    logic       ram_rd_en;
    logic [2:0] ram_rd_addr;
    logic [7:0] ram_rd_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic       done;

    logic [7:0] mem [8];

    beat_t  exp_q[$];
    raddr_t addr_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int zero_issued = 0;
    int zero_seen = 0;
    int timeouts = 0;
    int timeouts_seen = 0;
    int rdy_mode = 0;
    logic end_req = 1'b0;
    logic end_ack = 1'b0;

    logic       rst_pend = 1'b0;
    logic       done_due = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_hs = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    result_ram_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .count      (count),
        .ram_rd_en  (ram_rd_en),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: all comparisons happen here, sampled on the falling edge.
    always @(negedge clk) begin
        logic   nd;
        beat_t  b;
        raddr_t a;
        nd = 1'b0;
        chk("timeout_count", timeouts, timeouts_seen);
        timeouts_seen = timeouts;
        if (rst_pend) begin
            chk("rst_ram_rd_en", ram_rd_en, 0);
            chk("rst_ram_rd_addr", ram_rd_addr, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end
        rst_pend = !reset;
        if (!reset) begin
            done_due   = 1'b0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            zero_seen  = zero_issued;
        end else begin
            chk("done", done, done_due);
            if (done) chk("busy_at_done", busy, 0);
            if (zero_issued != zero_seen) begin
                zero_seen = zero_seen + 1;
                nd = 1'b1;
            end
            if (ram_rd_en) begin
                chk("rd_en_while_valid", out_valid, 0);
                if (addr_q.size() == 0) begin
                    chk("unexpected_rd_en", ram_rd_en, 0);
                end else begin
                    a = addr_q.pop_front();
                    chk("ram_rd_addr", ram_rd_addr, a.addr);
                    if (a.first) chk("rd_latency", cyc - a.acc, 1);
                end
            end
            if (prev_valid && !prev_hs) begin
                chk("valid_hold", out_valid, 1);
                chk("data_hold", out_data, prev_data);
                chk("last_hold", out_last, prev_last);
            end else if (out_valid) begin
                if (exp_q.size() == 0) chk("unexpected_beat", out_valid, 0);
                else if (exp_q[0].first) chk("valid_latency", cyc - exp_q[0].acc, 3);
            end
            if (out_valid) chk("busy_while_valid", busy, 1);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("beat_data", out_data, b.data);
                chk("beat_last", out_last, b.last);
                if (b.last) nd = 1'b1;
            end
            done_due   = nd;
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
        if (end_req && !end_ack) begin
            chk("leftover_beats", exp_q.size(), 0);
            chk("leftover_reads", addr_q.size(), 0);
            end_ack = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a start while the model is idle expands into its full list of reads and beats.
    task automatic issue(input logic [2:0] b, input logic [3:0] n);
        base_addr = b;
        count     = n;
        start     = 1'b1;
        if (reset && exp_q.size() == 0 && addr_q.size() == 0) begin
            if (n == 0) begin
                zero_issued++;
            end else begin
                for (int i = 0; i < int'(n); i++) begin
                    int ai;
                    ai = (int'(b) + i) % 8;
                    addr_q.push_back('{addr: 3'(ai), first: (i == 0), acc: cyc});
                    exp_q.push_back('{data: 8'(ai * 17), last: (i == int'(n) - 1),
                                      first: (i == 0), acc: cyc});
                end
            end
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) timeouts++;
    endtask

    task automatic wait_depth(input int depth, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > depth && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) timeouts++;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'(i * 17);
        reset     = 1'b0;
        start     = 1'b1;
        base_addr = 3'd0;
        count     = 4'd3;
        repeat (3) step();
        reset = 1'b1;
        start = 1'b0;
        step();

        rdy_mode = 0;
        issue(3'd1, 4'd3);
        wait_idle(50);
        step();

        issue(3'd6, 4'd4);
        wait_idle(50);
        step();

        issue(3'd0, 4'd3);
        wait_depth(2, 50);
        rdy_mode = 2;
        repeat (8) step();
        rdy_mode = 0;
        wait_idle(50);
        step();

        issue(3'd4, 4'd0);
        repeat (2) step();
        issue(3'd3, 4'd4);
        repeat (4) step();
        issue(3'd5, 4'd2);
        wait_idle(60);
        step();

        issue(3'd0, 4'd8);
        wait_depth(6, 60);
        reset = 1'b0;
        exp_q.delete();
        addr_q.delete();
        step();
        reset = 1'b1;
        step();
        issue(3'd2, 4'd1);
        wait_idle(50);
        step();

        rdy_mode = 1;
        for (int t = 0; t < 40; t++) begin
            issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 8)));
            if ($urandom_range(0, 3) == 0) begin
                repeat (2) step();
                issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 8)));
            end
            wait_idle(300);
            repeat ($urandom_range(0, 2)) step();
        end
        rdy_mode = 0;
        repeat (3) step();

        end_req = 1'b1;
        begin
            int n;
            n = 0;
            while (!end_ack && n < 10) begin
                step();
                n++;
            end
        end
        if (!end_ack) begin
            $display("FAIL end_handshake: monitor did not respond, required response within 10 cycles");
            $fatal(1);
        end
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
